// File: rtl/checkers_pkg.sv
// Shared definitions for the checkers board-state transmitter: piece codes,
// frame geometry and the sequencing FSM encoding.
package checkers_pkg;

    localparam logic [2:0] PIECE_EMPTY      = 3'd0;
    localparam logic [2:0] PIECE_LIGHT_MAN  = 3'd1;
    localparam logic [2:0] PIECE_DARK_MAN   = 3'd2;
    localparam logic [2:0] PIECE_LIGHT_KING = 3'd3;
    localparam logic [2:0] PIECE_DARK_KING  = 3'd4;

    localparam int FRAME_BYTES = 18;
    localparam int BOARD_BYTES = 16;
    localparam int UART_BITS   = 10;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_BIT,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } tx_state_e;

    // Two squares per board byte; the upper bit of each nibble is always zero.
    function automatic logic [7:0] pack_squares(input logic [2:0] sq_lo,
                                                input logic [2:0] sq_hi);
        return {1'b0, sq_hi, 1'b0, sq_lo};
    endfunction

endpackage

// File: rtl/checkers_uart_byte_tx.sv
// 8N1 byte serialiser: baud down-counter plus a 10-bit frame shift register.
// A load in the same cycle as byte_done chains bytes with no idle gap.
module checkers_uart_byte_tx
    import checkers_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       bit_tick,
    output logic [3:0] bit_pos,
    output logic       byte_done
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  STOP_POS    = 4'(UART_BITS - 1);

    logic [UART_BITS-1:0] shreg;
    logic [15:0]          baud_cnt;
    logic                 active;

    assign tx        = shreg[0];
    assign bit_tick  = ena & active & (baud_cnt == 16'd0);
    assign byte_done = bit_tick & (bit_pos == STOP_POS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '1;
            baud_cnt <= '0;
            bit_pos  <= '0;
            active   <= 1'b0;
        end else if (ena) begin
            if (load) begin
                shreg    <= {1'b1, data, 1'b0};
                baud_cnt <= BAUD_RELOAD;
                bit_pos  <= '0;
                active   <= 1'b1;
            end else if (active) begin
                if (baud_cnt == 16'd0) begin
                    baud_cnt <= BAUD_RELOAD;
                    if (bit_pos == STOP_POS) begin
                        // stop bit stays in shreg[0], so the line rests high
                        active   <= 1'b0;
                        bit_pos  <= '0;
                        baud_cnt <= '0;
                    end else begin
                        shreg   <= {1'b1, shreg[UART_BITS-1:1]};
                        bit_pos <= bit_pos + 4'd1;
                    end
                end else begin
                    baud_cnt <= baud_cnt - 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/checkers_board_tx.sv
// Streams an 18-byte board snapshot (sync, 16 board bytes, XOR checksum) as 8N1.
// state        | meaning
// ST_IDLE      | line idle, waiting for start
// ST_START_BIT | start bit on the line; next board byte prefetched here
// ST_DATA      | eight data bits, LSB first
// ST_STOP      | stop bit; chains the next byte or ends the frame
// ST_DONE      | one-cycle end-of-frame pulse; start here is accepted
module checkers_board_tx
    import checkers_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic [2:0] sq_data,
    output logic [4:0] sq_addr,
    output logic       sq_rd,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [4:0] LAST_IDX  = 5'(FRAME_BYTES - 1);
    localparam logic [4:0] CSUM_PREV = 5'(FRAME_BYTES - 2);

    tx_state_e   state, state_nxt;
    logic [4:0]  byte_idx;
    logic [4:0]  next_idx;
    logic [7:0]  csum;
    logic [2:0]  pf_lo, pf_hi;
    logic [1:0]  pf_step;
    logic [4:0]  sq_addr_q;
    logic        sq_rd_q;

    logic        frame_start;
    logic        load;
    logic        load_csum;
    logic [7:0]  load_data;
    logic        last_byte;

    logic        bit_tick;
    logic [3:0]  bit_pos;
    logic        byte_done;

    assign last_byte = (byte_idx == LAST_IDX);
    assign next_idx  = frame_start ? 5'd0 : byte_idx + 5'd1;
    assign sq_addr   = sq_addr_q;
    assign sq_rd     = sq_rd_q & ena;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (start) state_nxt = ST_START_BIT;
            ST_START_BIT: if (bit_tick) state_nxt = ST_DATA;
            ST_DATA:      if (bit_tick && bit_pos == 4'd8) state_nxt = ST_STOP;
            ST_STOP:      if (byte_done) state_nxt = last_byte ? ST_DONE : ST_START_BIT;
            ST_DONE:      state_nxt = start ? ST_START_BIT : ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_start = 1'b0;
        load        = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: frame_start = start & ena;
            ST_DONE: begin
                done        = 1'b1;
                frame_start = start & ena;
            end
            ST_STOP: begin
                busy = 1'b1;
                load = byte_done & ~last_byte;
            end
            default: busy = 1'b1;
        endcase
        if (frame_start) load = 1'b1;
        load_csum = ~frame_start & (byte_idx == CSUM_PREV);
        if (frame_start)    load_data = SYNC_BYTE;
        else if (load_csum) load_data = csum;
        else                load_data = pack_squares(pf_lo, pf_hi);
    end

    // Sequencing datapath: byte index, running checksum and the two-square prefetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx  <= '0;
            csum      <= '0;
            pf_lo     <= '0;
            pf_hi     <= '0;
            pf_step   <= '0;
            sq_addr_q <= '0;
            sq_rd_q   <= 1'b0;
        end else if (ena) begin
            if (load) begin
                byte_idx <= next_idx;
                if (frame_start)     csum <= '0;
                else if (!load_csum) csum <= csum ^ load_data;
                // next_idx below 16 means another board byte still has to be fetched
                if (!next_idx[4]) begin
                    sq_addr_q <= {next_idx[3:0], 1'b0};
                    sq_rd_q   <= 1'b1;
                    pf_step   <= 2'd1;
                end
            end else begin
                case (pf_step)
                    2'd1: begin
                        sq_addr_q <= sq_addr_q + 5'd1;
                        pf_step   <= 2'd2;
                    end
                    2'd2: begin
                        pf_lo   <= sq_data;
                        sq_rd_q <= 1'b0;
                        pf_step <= 2'd3;
                    end
                    2'd3: begin
                        pf_hi   <= sq_data;
                        pf_step <= 2'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

    checkers_uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .load      (load),
        .data      (load_data),
        .tx        (tx),
        .bit_tick  (bit_tick),
        .bit_pos   (bit_pos),
        .byte_done (byte_done)
    );

endmodule

// File: tb/tb_checkers_board_tx.sv
// Directed bench for checkers_board_tx: decodes the UART line, checks frame
// contents, frame length, start/done handshake, enable freeze and reset abort.
module tb_checkers_board_tx;
    import checkers_pkg::*;

    localparam int C         = 4;
    localparam int FRAME_CYC = 180 * C + 1;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ena     = 1'b1;
    logic       start   = 1'b0;
    logic [2:0] sq_data = 3'd0;
    logic [4:0] sq_addr;
    logic       sq_rd;
    logic       tx;
    logic       busy;
    logic       done;

    logic [2:0] board [32];
    logic [7:0] exp_b [18];
    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rx_q [$];
    int         rx_pos    = 0;
    bit         rx_act    = 1'b0;
    logic [7:0] rx_sh     = 8'h00;
    int         bit_i     = 0;
    int         frame_err = 0;
    int         rd_total  = 0;
    int         rd_bad    = 0;
    int         rd_idx    = 0;

    int rx_base, rd_base, rdbad_base, ferr_base;

    checkers_board_tx #(.CLKS_PER_BIT(C), .SYNC_BYTE(8'hA5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (start),
        .sq_data (sq_data),
        .sq_addr (sq_addr),
        .sq_rd   (sq_rd),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) sq_data <= board[sq_addr];

    // Line receiver and read-order monitor; only cycles with ena high advance the DUT.
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_act = 1'b0;
            rx_pos = 0;
            rd_idx = 0;
        end else if (ena) begin
            if (!busy) rd_idx = 0;
            if (sq_rd) begin
                if (sq_addr !== 5'(rd_idx)) rd_bad++;
                rd_idx++;
                rd_total++;
            end
            if (!rx_act && tx === 1'b0) begin
                rx_act = 1'b1;
                rx_pos = 0;
            end
            if (rx_act) begin
                if (rx_pos % C == C / 2) begin
                    bit_i = rx_pos / C;
                    if (bit_i == 0) begin
                        if (tx !== 1'b0) frame_err++;
                    end else if (bit_i <= 8) begin
                        rx_sh[bit_i-1] = tx;
                    end else begin
                        if (tx !== 1'b1) frame_err++;
                        rx_q.push_back(rx_sh);
                    end
                end
                if (rx_pos == 10 * C - 1) rx_act = 1'b0;
                else rx_pos++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp();
        logic [7:0] cs;
        cs       = 8'h00;
        exp_b[0] = 8'hA5;
        for (int k = 1; k <= 16; k++) begin
            exp_b[k] = {1'b0, board[2*k-1], 1'b0, board[2*k-2]};
            cs       = cs ^ exp_b[k];
        end
        exp_b[17] = cs;
    endtask

    task automatic frame_begin();
        rx_base    = rx_q.size();
        rd_base    = rd_total;
        rdbad_base = rd_bad;
        ferr_base  = frame_err;
        build_exp();
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_nbytes"}, 32'(rx_q.size() - rx_base), 32'd18);
        for (int i = 0; i < 18; i++) begin
            if (rx_base + i < rx_q.size())
                check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[rx_base+i]), 32'(exp_b[i]));
        end
        check({tag, "_nreads"}, 32'(rd_total - rd_base), 32'd32);
        check({tag, "_rd_order"}, 32'(rd_bad - rdbad_base), 32'd0);
        check({tag, "_framing"}, 32'(frame_err - ferr_base), 32'd0);
    endtask

    task automatic rx_byte(input string tag, input int idx, input logic [7:0] exp);
        if (rx_base + idx < rx_q.size()) check(tag, 32'(rx_q[rx_base+idx]), 32'(exp));
        else check(tag, 32'hFFFF_FFFF, 32'(exp));
    endtask

    task automatic start_frame(output int t0);
        @(posedge clk); #1;
        start = 1'b1;
        t0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit restart, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 4 * FRAME_CYC; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcyc = cyc;
                if (restart) start = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(dcyc >= 0), 32'd1);
    endtask

    task automatic wait_cycle(input int target);
        do begin
            @(posedge clk); #1;
        end while (cyc < target);
    endtask

    initial begin
        int t0, d, d2, frz_bad, done_bad;
        logic txf;

        for (int i = 0; i < 32; i++) board[i] = PIECE_EMPTY;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sq_rd", 32'(sq_rd), 32'd0);
        check("rst_sq_addr", 32'(sq_addr), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // empty board
        frame_begin();
        start_frame(t0);
        @(negedge clk);
        check("empty_c1_tx", 32'(tx), 32'd0);
        check("empty_c1_busy", 32'(busy), 32'd1);
        wait_done(1'b0, d);
        check("empty_done_cycle", 32'(d - t0), 32'(FRAME_CYC));
        check("empty_done_busy", 32'(busy), 32'd0);
        check("empty_done_tx", 32'(tx), 32'd1);
        rx_byte("empty_sync", 0, 8'hA5);
        rx_byte("empty_b8", 8, 8'h00);
        rx_byte("empty_csum", 17, 8'h00);
        check_frame("empty");
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);

        // opening position, with start pulsed mid-frame and in the done cycle
        for (int i = 0; i < 32; i++)
            board[i] = (i < 12) ? PIECE_DARK_MAN : (i < 20) ? PIECE_EMPTY : PIECE_LIGHT_MAN;
        frame_begin();
        start_frame(t0);
        wait_cycle(t0 + 100);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(1'b1, d);
        check("open_done_cycle", 32'(d - t0), 32'(FRAME_CYC));
        rx_byte("open_b1", 1, 8'h22);
        rx_byte("open_b6", 6, 8'h22);
        rx_byte("open_b7", 7, 8'h00);
        rx_byte("open_b16", 16, 8'h11);
        rx_byte("open_csum", 17, 8'h00);
        check_frame("open");

        // kings in the corner squares; this frame was launched from the done cycle
        for (int i = 0; i < 32; i++) board[i] = PIECE_EMPTY;
        board[0]  = PIECE_LIGHT_KING;
        board[31] = PIECE_DARK_KING;
        frame_begin();
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("restart_tx", 32'(tx), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        wait_done(1'b0, d2);
        check("kings_done_cycle", 32'(d2 - d), 32'(FRAME_CYC));
        rx_byte("kings_b1", 1, 8'h03);
        rx_byte("kings_b16", 16, 8'h40);
        rx_byte("kings_csum", 17, 8'h43);
        check_frame("kings");

        // enable held low for 50 cycles in the middle of a data bit
        for (int i = 0; i < 32; i++) board[i] = 3'(i % 8);
        frame_begin();
        start_frame(t0);
        wait_cycle(t0 + 1 + 40 * 3 + 4 * 3 + 1);
        ena = 1'b0;
        #1 txf = tx;
        check("pause_tx_bit", 32'(txf), 32'(exp_b[3][2]));
        frz_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== txf || busy !== 1'b1 || sq_rd !== 1'b0 || done !== 1'b0) frz_bad++;
            @(posedge clk);
        end
        #1 ena = 1'b1;
        check("pause_frozen", 32'(frz_bad), 32'd0);
        wait_done(1'b0, d);
        check("pause_done_cycle", 32'(d - t0), 32'(FRAME_CYC + 50));
        check_frame("pause");

        // reset in the middle of byte 5, then a clean frame
        start_frame(t0);
        wait_cycle(t0 + 1 + 40 * 5 + 10);
        rst_n = 1'b0;
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        done_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done !== 1'b0) done_bad++;
        end
        check("abort_no_done", 32'(done_bad), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        frame_begin();
        start_frame(t0);
        wait_done(1'b0, d);
        check("after_rst_done_cycle", 32'(d - t0), 32'(FRAME_CYC));
        rx_byte("after_rst_sync", 0, 8'hA5);
        check_frame("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
